// File: rtl/conv_window_gen.sv
`default_nettype none
//==============================================================================
// Module      : conv_window_gen
// Description : Raster-order pixel stream to 3x3 sliding window generator for
//               an unpadded convolution. It keeps two line buffers and a 3x3
//               shift register, and drives one window per valid output
//               position through a single-entry valid/ready output register.
// Revision    : 1.0 - initial release
//==============================================================================
module conv_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic signed [7:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic signed [7:0] win [0:8],
    output logic              win_valid,
    input  logic              win_ready,
    output logic              win_last
);

    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

    // Position of the next pixel to accept
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;

    // r_lb0 holds the previous row, r_lb1 the row before that
    logic signed [7:0] r_lb0 [0:IMG_W-1];
    logic signed [7:0] r_lb1 [0:IMG_W-1];

    // Sliding 3x3 window, row-major, index 2/5/8 is the newest column
    logic signed [7:0] r_sr  [0:8];
    logic signed [7:0] r_win [0:8];
    logic              r_win_valid;
    logic              r_win_last;

    logic              w_accept;
    logic              w_emit;
    logic              w_last_pos;
    logic signed [7:0] w_top;
    logic signed [7:0] w_mid;
    logic signed [7:0] w_sr_next [0:8];

    // Output register with pass-through: a new pixel may enter whenever the
    // held window is empty or leaving this cycle.
    assign pix_ready  = !r_win_valid || win_ready;
    assign w_accept   = pix_valid && pix_ready;
    assign w_emit     = w_accept && (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);
    assign w_last_pos = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    assign w_top      = r_lb1[r_col];
    assign w_mid      = r_lb0[r_col];

    assign win       = r_win;
    assign win_valid = r_win_valid;
    assign win_last  = r_win_last;

    // Next window contents: shift columns left, insert {top, mid, pixel}
    always_comb begin
        w_sr_next[0] = r_sr[1];
        w_sr_next[1] = r_sr[2];
        w_sr_next[2] = w_top;
        w_sr_next[3] = r_sr[4];
        w_sr_next[4] = r_sr[5];
        w_sr_next[5] = w_mid;
        w_sr_next[6] = r_sr[7];
        w_sr_next[7] = r_sr[8];
        w_sr_next[8] = pix_in;
    end

    // Raster position counters, wrapping at row end and frame end
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffers age by one row at the accepted column; contents are not
    // reset because stale rows are masked by the row >= 2 emit gate.
    always_ff @(posedge Clk) begin
        if (!reset && w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= pix_in;
        end
    end

    // Window shift register advances on every accepted pixel
    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) r_sr[k] <= '0;
        end else if (w_accept) begin
            r_sr <= w_sr_next;
        end
    end

    // Output register: load on emit, drop valid when consumed with no reload
    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) r_win[k] <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else if (w_emit) begin
            r_win       <= w_sr_next;
            r_win_valid <= 1'b1;
            r_win_last  <= w_last_pos;
        end else if (r_win_valid && win_ready) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end
    end

endmodule
`default_nettype wire
